// File: rtl/toggle_mon_pkg.sv
// Shared types and default widths for the toggle-rate monitor.
package toggle_mon_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned WIN_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_e;

endpackage : toggle_mon_pkg

// File: rtl/toggle_rate_monitor_sync_edge_det.sv
// Synchroniser chain for an asynchronous level plus a one-cycle change pulse.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic level,
  output logic tog
);

  // A single flop is not a synchroniser, so the chain is never shorter than 2.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q, sync_d;
  logic              q_prev_q, q_prev_d;

  // Shift the raw input into the chain; remember last synchronised level.
  always_comb begin
    sync_d   = {sync_q[STAGES-2:0], d_async};
    q_prev_d = sync_q[STAGES-1];
  end

  // Chain and previous-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      q_prev_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      q_prev_q <= q_prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign tog   = sync_q[STAGES-1] ^ q_prev_q;

endmodule : sync_edge_det

// File: rtl/toggle_rate_monitor.sv
// Counts Q toggles over a requested window and reports via valid/ready.
module toggle_rate_monitor
  import toggle_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WIN_W       = WIN_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             stuck,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_inc;
  logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
  logic               stuck_q, stuck_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               tog;
  logic               q_level_unused;   // only the change pulse matters here
  logic               start_ok;
  logic               last_cycle;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (q_in),
    .level   (q_level_unused),
    .tog     (tog)
  );

  assign start_ok   = start && (win_len != '0);
  assign last_cycle = (win_q == WIN_W'(1));
  assign count_inc  = (tog && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)   state_d = MEASURE;
      MEASURE: if (last_cycle) state_d = REPORT;
      REPORT:  if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath and output next values; flags follow the state being entered.
  always_comb begin
    win_d       = win_q;
    count_d     = count_q;
    cnt_out_d   = cnt_out_q;
    stuck_d     = stuck_q;
    out_valid_d = (state_d == REPORT);
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          win_d   = win_len;
          count_d = '0;
        end
      end
      MEASURE: begin
        win_d   = win_q - WIN_W'(1);
        count_d = count_inc;
        if (last_cycle) begin
          cnt_out_d = count_inc;
          stuck_d   = (count_inc == '0);
        end
      end
      REPORT: begin
        if (out_ready) stuck_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      count_q     <= '0;
      cnt_out_q   <= '0;
      stuck_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      win_q       <= win_d;
      count_q     <= count_d;
      cnt_out_q   <= cnt_out_d;
      stuck_q     <= stuck_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign cnt_out   = cnt_out_q;
  assign stuck     = stuck_q;
  assign out_valid = out_valid_q;

endmodule : toggle_rate_monitor

// File: tb/tb_toggle_rate_monitor.sv
// Randomised bench for toggle_rate_monitor with a sample-history reference model.
module tb_toggle_rate_monitor;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned SAT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             q_in = 1'b0;
  logic             start = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIN_W-1:0] win_len = '0;

  logic             busy, stuck, out_valid;
  logic [CNT_W-1:0] cnt_out;
  logic             busy_s, stuck_s, out_valid_s;
  logic [SAT_W-1:0] cnt_out_s;

  toggle_rate_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .start(start), .win_len(win_len),
    .busy(busy), .cnt_out(cnt_out), .stuck(stuck), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  toggle_rate_monitor #(.CNT_W(SAT_W), .WIN_W(WIN_W), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .start(start), .win_len(win_len),
    .busy(busy_s), .cnt_out(cnt_out_s), .stuck(stuck_s), .out_valid(out_valid_s),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  int unsigned qmode = 0;   // 0 hold, 1 toggle each cycle, 2 toggle every 2 cycles, 3 random, 4 force 0
  int unsigned phase = 0;
  bit          hist[$];     // q_in as seen at each rising edge since reset release
  int unsigned last_exp = 0;

  // Sampled level at edge n; flops start from 0, so anything before release is 0.
  function automatic bit s(int n);
    if (n < 0 || n >= hist.size()) return 1'b0;
    return hist[n];
  endfunction

  // Toggles counted at edge t are level changes between samples t-3 and t-2.
  function automatic int unsigned model_count(int k, int unsigned w);
    int unsigned c = 0;
    for (int t = k + 1; t <= k + int'(w); t++) if (s(t-2) != s(t-3)) c++;
    return c;
  endfunction

  function automatic int unsigned sat(int unsigned c, int unsigned w);
    int unsigned m = (32'd1 << w) - 32'd1;
    return (c > m) ? m : c;
  endfunction

  // One clock: drive inputs at negedge, record q_in at the edge, settle.
  task automatic tick(input logic st, input logic [WIN_W-1:0] wl, input logic rdy);
    @(negedge clk);
    start = st; win_len = wl; out_ready = rdy;
    case (qmode)
      1: q_in = ~q_in;
      2: begin phase++; if (phase % 2 == 0) q_in = ~q_in; end
      3: q_in = 1'($urandom % 2);
      4: q_in = 1'b0;
      default: ;
    endcase
    @(posedge clk);
    hist.push_back(q_in);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; hist.delete();
    @(posedge clk);
    hist.push_back(q_in);
    #1;
  endtask

  // Full measurement: start, window, optional stall in REPORT, handshake.
  task automatic measure(input int unsigned w, input int unsigned stall, input string tag);
    int          k;
    int unsigned exp_c;
    tick(1'b1, WIN_W'(w), stall == 0);
    k = hist.size() - 1;
    tests_run++;
    if (busy !== 1'b1 || busy_s !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s start: busy=%b busy_s=%b out_valid=%b expected 1 1 0", tag, busy, busy_s, out_valid);
    end
    for (int i = 1; i < int'(w); i++) begin
      tick(1'b0, '0, stall == 0);
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s window cyc %0d: out_valid=%b busy=%b expected 0 1", tag, i, out_valid, busy);
      end
    end
    tick(1'b0, '0, stall == 0);
    exp_c = model_count(k, w);
    last_exp = exp_c;
    tests_run++;
    if (out_valid !== 1'b1 || out_valid_s !== 1'b1 || busy !== 1'b1 ||
        cnt_out !== CNT_W'(sat(exp_c, CNT_W)) || cnt_out_s !== SAT_W'(sat(exp_c, SAT_W)) ||
        stuck !== (exp_c == 0) || stuck_s !== (exp_c == 0)) begin
      tests_failed++;
      $display("FAIL %s report: valid=%b busy=%b cnt=%0d cnt3=%0d stuck=%b expected 1 1 %0d %0d %b",
               tag, out_valid, busy, cnt_out, cnt_out_s, stuck,
               sat(exp_c, CNT_W), sat(exp_c, SAT_W), exp_c == 0);
    end
    for (int i = 0; i < int'(stall); i++) begin
      tick(i == 1, WIN_W'(5), 1'b0);
      tests_run++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || cnt_out !== CNT_W'(sat(exp_c, CNT_W)) ||
          stuck !== (exp_c == 0)) begin
        tests_failed++;
        $display("FAIL %s hold %0d: valid=%b busy=%b cnt=%0d stuck=%b expected 1 1 %0d %b",
                 tag, i, out_valid, busy, cnt_out, stuck, sat(exp_c, CNT_W), exp_c == 0);
      end
    end
    tick(1'b0, '0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || stuck !== 1'b0 || stuck_s !== 1'b0 ||
        cnt_out !== CNT_W'(sat(exp_c, CNT_W))) begin
      tests_failed++;
      $display("FAIL %s accept: valid=%b busy=%b stuck=%b stuck3=%b cnt=%0d expected 0 0 0 0 %0d",
               tag, out_valid, busy, stuck, stuck_s, cnt_out, sat(exp_c, CNT_W));
    end
  endtask

  task automatic test_reset();
    q_in = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || cnt_out !== '0 || stuck !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b cnt=%0d stuck=%b valid=%b expected all 0", busy, cnt_out, stuck, out_valid);
    end
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    release_reset();
  endtask

  // Q already high at release produces exactly one counted toggle.
  task automatic test_release_toggle();
    qmode = 0;
    measure(4, 0, "release_tog");
    tests_run++;
    if (cnt_out !== CNT_W'(1)) begin
      tests_failed++;
      $display("FAIL release_tog: cnt=%0d expected 1", cnt_out);
    end
  endtask

  task automatic test_nominal();
    qmode = 2;
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);
    measure(10, 0, "nominal");
    tests_run++;
    if (cnt_out !== CNT_W'(5)) begin
      tests_failed++;
      $display("FAIL nominal: cnt=%0d expected 5", cnt_out);
    end
  endtask

  task automatic test_saturation();
    qmode = 1;
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);
    measure(20, 0, "saturation");
    tests_run++;
    if (cnt_out_s !== SAT_W'(7) || cnt_out !== CNT_W'(20)) begin
      tests_failed++;
      $display("FAIL saturation: cnt3=%0d cnt16=%0d expected 7 20", cnt_out_s, cnt_out);
    end
  endtask

  task automatic test_stuck();
    qmode = 4;
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1);
    measure(8, 0, "stuck");
    tests_run++;
    if (cnt_out !== '0 || cnt_out_s !== '0) begin
      tests_failed++;
      $display("FAIL stuck: cnt=%0d cnt3=%0d expected 0 0", cnt_out, cnt_out_s);
    end
  endtask

  task automatic test_backpressure();
    qmode = 3;
    measure(12, 5, "backpressure");
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, 1'b1);
      tests_run++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure idle %0d: busy=%b valid=%b expected 0 0", i, busy, out_valid);
      end
    end
  endtask

  task automatic test_zero_window();
    tick(1'b1, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL zero_window %0d: busy=%b valid=%b expected 0 0", i, busy, out_valid);
      end
      tick(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    qmode = 3;
    measure(3, 0, "b2b_a");
    measure(5, 0, "b2b_b");
    measure(1, 0, "b2b_c");
  endtask

  task automatic test_reset_mid_measure();
    qmode = 3;
    tick(1'b1, WIN_W'(10), 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || cnt_out !== '0 || stuck !== 1'b0 || out_valid !== 1'b0 ||
        busy_s !== 1'b0 || out_valid_s !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b cnt=%0d stuck=%b valid=%b expected all 0", busy, cnt_out, stuck, out_valid);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1);
    release_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, '0, 1'b1);
      tests_run++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid after %0d: busy=%b valid=%b expected 0 0", i, busy, out_valid);
      end
    end
    measure(7, 0, "after_reset");
  endtask

  task automatic test_random();
    qmode = 3;
    for (int n = 0; n < 8; n++)
      measure($urandom_range(30, 1), $urandom_range(3, 0), $sformatf("random%0d", n));
  endtask

  initial begin
    test_reset();
    test_release_toggle();
    test_nominal();
    test_saturation();
    test_stuck();
    test_backpressure();
    test_zero_window();
    test_back_to_back();
    test_reset_mid_measure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_toggle_rate_monitor
